// File: rtl/bus_arbiter.sv
// Round-robin arbiter sharing one single-word W_* bus among up to four requesters.
// Optional bus watchdog compiled in with `define ARB_TIMEOUT_EN.
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | waiting for a request; grants the first requester at/after ptr
// ST_BUSY    | bus cycle in flight, waiting for W_ACK (or watchdog expiry)
// ST_RELEASE | ack pulse visible; requests ignored so the winner can drop m_req
module bus_arbiter #(
    parameter int NM      = 4,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              W_RST,
    input  logic [NM-1:0]     m_req,
    input  logic [NM-1:0]     m_write,
    input  logic [32*NM-1:0]  m_addr,
    input  logic [32*NM-1:0]  m_wdata,
    output logic [NM-1:0]     m_ack,
    output logic [NM-1:0]     m_err,
    output logic [31:0]       m_rdata,
    output logic [1:0]        m_gnt,
    output logic              W_CYC,
    output logic [31:0]       W_ADDR,
    output logic [31:0]       W_DATA_O,
    output logic              W_WRITE,
    input  logic              W_ACK,
    input  logic [31:0]       W_DATA_I
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_BUSY    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [1:0]    ptr_q, ptr_d;
    logic [1:0]    gnt_q, gnt_d;
    logic          cyc_q, cyc_d;
    logic          write_q, write_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   rdata_q, rdata_d;
    logic [NM-1:0] ack_q, ack_d;

    logic [3:0]    req_pad;
    logic [3:0]    write_pad;
    logic [127:0]  addr_pad;
    logic [127:0]  wdata_pad;
    logic          pick_vld;
    logic [1:0]    pick_idx;
    logic [1:0]    ptr_next;
    logic [NM-1:0] gnt_oh;

    // Unused upper requester slots read as idle when NM < 4.
    assign req_pad   = 4'(m_req);
    assign write_pad = 4'(m_write);
    assign addr_pad  = 128'(m_addr);
    assign wdata_pad = 128'(m_wdata);

`ifdef ARB_TIMEOUT_EN
    logic [7:0]    wdt_q, wdt_d;
    logic [NM-1:0] err_q, err_d;
    logic          wdt_exp;

    // Expiry fires on the edge where the count would reach TIMEOUT.
    assign wdt_exp = (wdt_q == 8'(TIMEOUT - 1));
    assign m_err   = err_q;
`else
    assign m_err   = '0;
`endif

    // Scan from highest offset down so the closest requester to ptr wins.
    always_comb begin : pick
        int c;
        pick_vld = 1'b0;
        pick_idx = 2'd0;
        c        = 0;
        for (int off = NM - 1; off >= 0; off--) begin
            c = int'(ptr_q) + off;
            if (c >= NM) c = c - NM;
            if (req_pad[c[1:0]]) begin
                pick_vld = 1'b1;
                pick_idx = c[1:0];
            end
        end
    end

    always_comb begin : next_ptr
        int s;
        s = int'(gnt_q) + 1;
        if (s >= NM) s = 0;
        ptr_next = s[1:0];
    end

    always_comb begin
        gnt_oh = '0;
        for (int i = 0; i < NM; i++) begin
            gnt_oh[i] = (int'(gnt_q) == i);
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        gnt_d   = gnt_q;
        cyc_d   = cyc_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack_d   = '0;
`ifdef ARB_TIMEOUT_EN
        wdt_d   = wdt_q;
        err_d   = '0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    gnt_d   = pick_idx;
                    addr_d  = addr_pad[32*int'(pick_idx) +: 32];
                    wdata_d = wdata_pad[32*int'(pick_idx) +: 32];
                    write_d = write_pad[pick_idx];
                    cyc_d   = 1'b1;
                    state_d = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
                    wdt_d   = 8'd0;
`endif
                end
            end
            ST_BUSY: begin
                if (W_ACK) begin
                    rdata_d = write_q ? 32'h0 : W_DATA_I;
                    ack_d   = gnt_oh;
                    cyc_d   = 1'b0;
                    ptr_d   = ptr_next;
                    state_d = ST_RELEASE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (wdt_exp) begin
                    rdata_d = 32'h0;
                    ack_d   = gnt_oh;
                    err_d   = gnt_oh;
                    cyc_d   = 1'b0;
                    ptr_d   = ptr_next;
                    state_d = ST_RELEASE;
                end else begin
                    wdt_d   = wdt_q + 8'd1;
                end
`endif
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (W_RST) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            gnt_q   <= 2'd0;
            cyc_q   <= 1'b0;
            write_q <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            ack_q   <= '0;
`ifdef ARB_TIMEOUT_EN
            wdt_q   <= 8'd0;
            err_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            cyc_q   <= cyc_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ack_q   <= ack_d;
`ifdef ARB_TIMEOUT_EN
            wdt_q   <= wdt_d;
            err_q   <= err_d;
`endif
        end
    end

    assign m_ack    = ack_q;
    assign m_rdata  = rdata_q;
    assign m_gnt    = gnt_q;
    assign W_CYC    = cyc_q;
    assign W_ADDR   = addr_q;
    assign W_DATA_O = wdata_q;
    assign W_WRITE  = write_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: vector table of single transactions, ack scoreboard,
// and hand sequences for reset abort, fairness, spurious ack and watchdog.
module tb_bus_arbiter;

    logic         clk = 1'b0;
    logic         W_RST;
    logic [3:0]   m_req, m_write;
    logic [127:0] m_addr, m_wdata;
    logic [3:0]   m_ack, m_err;
    logic [31:0]  m_rdata;
    logic [1:0]   m_gnt;
    logic         W_CYC, W_WRITE, W_ACK;
    logic [31:0]  W_ADDR, W_DATA_O, W_DATA_I;

    bus_arbiter #(.NM(4), .TIMEOUT(16)) dut (
        .clk(clk), .W_RST(W_RST), .m_req(m_req), .m_write(m_write),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_ack(m_ack), .m_err(m_err),
        .m_rdata(m_rdata), .m_gnt(m_gnt), .W_CYC(W_CYC), .W_ADDR(W_ADDR),
        .W_DATA_O(W_DATA_O), .W_WRITE(W_WRITE), .W_ACK(W_ACK), .W_DATA_I(W_DATA_I)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          idx;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] bus_rd;
        int          dly;
        logic [31:0] exp_rd;
    } vec_t;

    typedef struct {
        logic [3:0]  ack;
        logic [3:0]  err;
        logic [31:0] rdata;
        logic [1:0]  gnt;
    } exp_t;

    exp_t sb[$];
    int   ack_times[$];
    int   errors = 0;
    int   checks = 0;
    int   cyc_cnt = 0;
    logic [31:0] last_rd;
    vec_t vecs[5];

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Every ack pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (m_ack !== 4'b0) begin
            ack_times.push_back(cyc_cnt);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got m_ack=%b with nothing outstanding", m_ack);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("sb_ack",   32'(m_ack),   32'(e.ack));
                chk("sb_err",   32'(m_err),   32'(e.err));
                chk("sb_rdata", m_rdata,      e.rdata);
                chk("sb_gnt",   32'(m_gnt),   32'(e.gnt));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input string name, output bit got);
        got = 1'b0;
        for (int n = 0; n < 8; n++) begin
            tick();
            if (W_CYC) begin
                got = 1'b1;
                break;
            end
        end
        chk(name, 32'(got), 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        bit got;
        m_write[v.idx]          = v.wr;
        m_addr[32*v.idx +: 32]  = v.addr;
        m_wdata[32*v.idx +: 32] = v.wdata;
        m_req[v.idx]            = 1'b1;
        wait_cyc({tag, "_grant"}, got);
        if (!got) begin
            m_req = 4'b0;
            return;
        end
        chk({tag, "_addr"},  W_ADDR,          v.addr);
        chk({tag, "_write"}, 32'(W_WRITE),    32'(v.wr));
        chk({tag, "_wdata"}, W_DATA_O,        v.wdata);
        chk({tag, "_gnt"},   32'(m_gnt),      32'(v.idx));
        // Requester changes after the grant must not reach the bus.
        m_addr[32*v.idx +: 32]  = ~v.addr;
        m_wdata[32*v.idx +: 32] = ~v.wdata;
        m_write[v.idx]          = ~v.wr;
        repeat (v.dly - 1) tick();
        chk({tag, "_hold_cyc"},   32'(W_CYC),   32'd1);
        chk({tag, "_hold_addr"},  W_ADDR,       v.addr);
        chk({tag, "_hold_write"}, 32'(W_WRITE), 32'(v.wr));
        W_ACK    = 1'b1;
        W_DATA_I = v.bus_rd;
        sb.push_back('{ack: 4'(1 << v.idx), err: 4'b0, rdata: v.exp_rd, gnt: 2'(v.idx)});
        tick();
        W_ACK        = 1'b0;
        m_req[v.idx] = 1'b0;
        chk({tag, "_cyc_drop"}, 32'(W_CYC), 32'd0);
        last_rd = v.exp_rd;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit got;
        int base;
        m_req = 4'b0; m_write = 4'b0; m_addr = '1; m_wdata = '1;
        W_ACK = 1'b0; W_DATA_I = 32'h0; W_RST = 1'b1;
        last_rd = 32'h0;

        vecs[0] = '{idx: 2, wr: 1'b0, addr: 32'h100,      wdata: 32'h0,        bus_rd: 32'hCAFE0001, dly: 3, exp_rd: 32'hCAFE0001};
        vecs[1] = '{idx: 0, wr: 1'b1, addr: 32'h40,       wdata: 32'h55AA55AA, bus_rd: 32'hDEADBEEF, dly: 1, exp_rd: 32'h0};
        vecs[2] = '{idx: 3, wr: 1'b0, addr: 32'h0000FFFC, wdata: 32'h11111111, bus_rd: 32'h12345678, dly: 1, exp_rd: 32'h12345678};
        vecs[3] = '{idx: 1, wr: 1'b1, addr: 32'h80000000, wdata: 32'hA5A50F0F, bus_rd: 32'h99999999, dly: 2, exp_rd: 32'h0};
        vecs[4] = '{idx: 1, wr: 1'b0, addr: 32'h00000004, wdata: 32'h0,        bus_rd: 32'hFFFFFFFF, dly: 5, exp_rd: 32'hFFFFFFFF};

        tick();
        tick();
        chk("rst_cyc",   32'(W_CYC),   32'd0);
        chk("rst_addr",  W_ADDR,       32'h0);
        chk("rst_wdata", W_DATA_O,     32'h0);
        chk("rst_write", 32'(W_WRITE), 32'd0);
        chk("rst_ack",   32'(m_ack),   32'd0);
        chk("rst_err",   32'(m_err),   32'd0);
        chk("rst_rdata", m_rdata,      32'h0);
        chk("rst_gnt",   32'(m_gnt),   32'd0);
        W_RST = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Spurious ack in IDLE: no pulse, no bus cycle, read data untouched.
        W_ACK = 1'b1; W_DATA_I = 32'h77777777;
        tick();
        W_ACK = 1'b0;
        tick();
        chk("spur_cyc",   32'(W_CYC), 32'd0);
        chk("spur_rdata", m_rdata,    last_rd);
        run_vec(vecs[2], "post_spur");

        // Reset abort: move ptr past 1, abort requester 1, then 1 and 3 compete.
        run_vec(vecs[0], "pre_abort");
        m_write[1] = 1'b0; m_addr[63:32] = 32'h200; m_req[1] = 1'b1;
        wait_cyc("abort_grant", got);
        chk("abort_gnt", 32'(m_gnt), 32'd1);
        tick();
        W_RST = 1'b1;
        tick();
        chk("abort_cyc",   32'(W_CYC),   32'd0);
        chk("abort_addr",  W_ADDR,       32'h0);
        chk("abort_write", 32'(W_WRITE), 32'd0);
        chk("abort_rdata", m_rdata,      32'h0);
        chk("abort_gnt0",  32'(m_gnt),   32'd0);
        chk("abort_ack",   32'(m_ack),   32'd0);
        W_RST = 1'b0;
        m_write[3] = 1'b0; m_addr[127:96] = 32'h300; m_req[3] = 1'b1;
        wait_cyc("reabort_grant", got);
        chk("reabort_gnt",  32'(m_gnt), 32'd1);
        chk("reabort_addr", W_ADDR,     32'h200);
        W_ACK = 1'b1; W_DATA_I = 32'h0000ABCD;
        sb.push_back('{ack: 4'b0010, err: 4'b0, rdata: 32'h0000ABCD, gnt: 2'd1});
        tick();
        W_ACK = 1'b0; m_req = 4'b0;
        tick();

        // Fairness: reset ptr, everyone requests, bus acks immediately.
        W_RST = 1'b1;
        tick();
        W_RST = 1'b0;
        m_write = 4'b0;
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{ack: 4'(1 << (i % 4)), err: 4'b0, rdata: 32'h0BADF00D, gnt: 2'(i % 4)});
        end
        base = ack_times.size();
        W_DATA_I = 32'h0BADF00D; W_ACK = 1'b1; m_req = 4'hF;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            #1;
            if (ack_times.size() >= base + 5) break;
        end
        m_req = 4'b0; W_ACK = 1'b0;
        chk("fair_count", 32'(ack_times.size() - base), 32'd5);
        if (ack_times.size() >= base + 5) begin
            for (int i = 1; i < 5; i++) begin
                chk($sformatf("fair_gap%0d", i),
                    32'(ack_times[base + i] - ack_times[base + i - 1]), 32'd3);
            end
        end
        tick();
        tick();

`ifdef ARB_TIMEOUT_EN
        // Watchdog expiry with no ack, then ack exactly on the expiry edge.
        m_write[3] = 1'b0; m_addr[127:96] = 32'h400; m_req[3] = 1'b1;
        wait_cyc("wdt_grant", got);
        sb.push_back('{ack: 4'b1000, err: 4'b1000, rdata: 32'h0, gnt: 2'd3});
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 15) begin
                chk("wdt_pre_cyc", 32'(W_CYC), 32'd1);
                chk("wdt_pre_ack", 32'(m_ack), 32'd0);
            end
        end
        chk("wdt_ack", 32'(m_ack), 32'b1000);
        chk("wdt_err", 32'(m_err), 32'b1000);
        chk("wdt_cyc", 32'(W_CYC), 32'd0);
        m_req[3] = 1'b0;
        tick();
        m_req[3] = 1'b1;
        wait_cyc("wdt2_grant", got);
        sb.push_back('{ack: 4'b1000, err: 4'b0, rdata: 32'h5A5A5A5A, gnt: 2'd3});
        repeat (15) tick();
        W_ACK = 1'b1; W_DATA_I = 32'h5A5A5A5A;
        tick();
        W_ACK = 1'b0; m_req[3] = 1'b0;
        chk("wdt2_ack", 32'(m_ack), 32'b1000);
        chk("wdt2_err", 32'(m_err), 32'd0);
        tick();
`else
        // Without the watchdog, an unacknowledged cycle stays open.
        m_write[3] = 1'b0; m_addr[127:96] = 32'h400; m_req[3] = 1'b1;
        wait_cyc("nowdt_grant", got);
        repeat (20) tick();
        chk("nowdt_cyc", 32'(W_CYC), 32'd1);
        chk("nowdt_ack", 32'(m_ack), 32'd0);
        W_ACK = 1'b1; W_DATA_I = 32'h5A5A5A5A;
        sb.push_back('{ack: 4'b1000, err: 4'b0, rdata: 32'h5A5A5A5A, gnt: 2'd3});
        tick();
        W_ACK = 1'b0; m_req[3] = 1'b0;
        tick();
`endif

        tick();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Round-robin arbiter that shares the single W_* memory bus between up to four requesters: CPU thread fetch ports, DMA and debug. It sits between the requesters' FETCH-style ports and the W_ADDR/W_DATA_O/W_WRITE/W_ACK/W_DATA_I bus. It serialises one single-word transaction per grant and returns read data and an acknowledge to the winning requester. An optional watchdog aborts transactions the bus never acknowledges.

## Interface
Parameters:
- NM, 4: number of requesters, 1..4.
- TIMEOUT, 255: watchdog limit in clk cycles (only used with the watchdog compiled in); 8-bit counter.

Ports:
- clk  in  1  system clock; all logic on posedge.
- W_RST  in  1  synchronous, active-high reset.
- m_req  in  NM  per-requester request; held high until that requester's m_ack.
- m_write  in  NM  per-requester write flag.
- m_addr  in  32*NM  requester i address at [32*i+31:32*i].
- m_wdata  in  32*NM  requester i write data, same slicing.
- m_ack  out  NM  one-cycle completion pulse to the granted requester.
- m_err  out  NM  one-cycle error pulse, coincident with m_ack; constant 0 without the watchdog.
- m_rdata  out  32  read data, valid in the m_ack cycle; shared by all requesters.
- m_gnt  out  2  index of the current or last grant (debug/thread tag).
- W_CYC  out  1  bus cycle active; qualifies W_ADDR/W_DATA_O/W_WRITE.
- W_ADDR  out  32  bus address.
- W_DATA_O  out  32  bus write data.
- W_WRITE  out  1  bus write enable.
- W_ACK  in  1  bus acknowledge; sampled only while W_CYC=1.
- W_DATA_I  in  32  bus read data; sampled with W_ACK.

## Operation
- Reset values: m_ack=0, m_err=0, m_rdata=0, m_gnt=0, W_CYC=0, W_ADDR=0, W_DATA_O=0, W_WRITE=0. Round-robin pointer=0, state=IDLE.
- State machine IDLE -> BUSY -> RELEASE -> IDLE:
  - IDLE: if any m_req bit in 0..NM-1 is set, select the first set bit at or after the pointer, wrapping modulo NM. Register m_gnt, latch that requester's addr, wdata and write onto W_ADDR/W_DATA_O/W_WRITE, set W_CYC=1, go to BUSY. With no requests, stay in IDLE.
  - BUSY: bus outputs held constant. On W_ACK=1: m_rdata<=W_DATA_I (or 0 for a write), m_ack[m_gnt]<=1, W_CYC<=0, pointer<=(m_gnt+1) mod NM, go to RELEASE.
  - RELEASE: m_ack/m_err return to 0. Requests are ignored for this one cycle so the served requester can drop m_req. Then go to IDLE.
- Fairness: a continuously requesting master waits at most NM-1 transactions.
- Requester inputs are sampled only in the IDLE grant cycle. Later changes do not affect the bus until the next grant.
- m_req bits at index >= NM are ignored.
- W_ACK outside BUSY is ignored.
- W_RST mid-transaction: next edge forces the reset values. No m_ack is issued for the aborted transfer, and the pointer returns to 0.

## Timing
- Request at edge N (seen in IDLE): W_CYC=1 after edge N.
- W_ACK high in cycle k: m_ack/m_rdata valid after edge k and W_CYC low the same cycle.
- Minimum transaction with W_ACK in the first BUSY cycle: request to m_ack is 2 cycles.
- Back-to-back grants are 3 cycles apart (IDLE, BUSY, RELEASE).
- Round-robin pointer updates only on completion, never on reset-abort.

## Configuration
- ARB_TIMEOUT_EN defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle without W_ACK.
  - When it reaches TIMEOUT: m_ack and m_err pulse for m_gnt, m_rdata<=32'h0, W_CYC<=0, pointer advances, go to RELEASE.
  - If W_ACK and expiry coincide, W_ACK wins and m_err stays 0.
- ARB_TIMEOUT_EN undefined: no counter. BUSY waits indefinitely, and m_err is tied to 0.

## Test plan
- Single read: reset, requester 2 reads addr 32'h100, bus acks after 3 cycles with 32'hCAFE0001 -> W_ADDR=32'h100, W_WRITE=0; m_ack[2] for exactly one cycle; m_rdata=32'hCAFE0001; m_gnt=2.
- Write: requester 0 writes 32'h55AA55AA to 32'h40 -> W_DATA_O=32'h55AA55AA, W_WRITE=1 until W_ACK; m_ack[0] pulse; m_rdata=0.
- Fairness: all four requesters assert continuously with immediate ack -> grant order 0,1,2,3,0 and m_ack pulses exactly 3 cycles apart.
- Reset mid-transaction: grant requester 1, assert W_RST in the second BUSY cycle -> W_CYC=0 and all outputs 0 after the edge; no m_ack; the next grant goes to the lowest requesting index starting from 0.
- Watchdog (ARB_TIMEOUT_EN, TIMEOUT=16): requester 3 reads, W_ACK never asserts -> m_ack[3] and m_err[3] pulse 16 cycles after W_CYC rises; m_rdata=0. Repeat with W_ACK exactly at expiry -> m_err=0.
- Spurious ack: pulse W_ACK while in IDLE -> no m_ack and no state change.
